// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key codes and entry-FSM state type for the key entry adder.
//   KEY_* localparams : 4-bit scanner codes of the non-digit keys
//   state_t           : ENTER_A / ENTER_B / ADD / DONE
package keypad_pkg;

   localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
   localparam logic [3:0] KEY_PLUS      = 4'hA;
   localparam logic [3:0] KEY_CLR_ENTRY = 4'hB;
   localparam logic [3:0] KEY_CLR_ALL   = 4'hC;
   localparam logic [3:0] KEY_EQUALS    = 4'hD;

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      ADD     = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: combinational double-dabble binary to packed-BCD converter.
// Only compiled when KEY_ENTRY_BCD_OUT_EN is defined.
//   bin [IN_W-1:0]         : unsigned binary input
//   bcd [4*DIGITS_N-1:0]   : packed BCD, least significant digit in bits [3:0]
`ifdef KEY_ENTRY_BCD_OUT_EN
module bin_to_bcd #(
   parameter int IN_W     = 11,
   parameter int DIGITS_N = 4
) (
   input  logic [IN_W-1:0]       bin,
   output logic [4*DIGITS_N-1:0] bcd
);

   localparam int BCD_W = 4 * DIGITS_N;

   logic [BCD_W-1:0] acc_s;

   // Shift-and-add-3: correct every digit >= 5 before each shift so it carries into the next digit.
   always_comb begin
      acc_s = {BCD_W{1'b0}};
      for (int i = IN_W - 1; i >= 0; i--) begin
         for (int d = 0; d < DIGITS_N; d++) begin
            if (acc_s[4*d +: 4] >= 4'd5) begin
               acc_s[4*d +: 4] = acc_s[4*d +: 4] + 4'd3;
            end else begin
               acc_s[4*d +: 4] = acc_s[4*d +: 4];
            end
         end
         acc_s = {acc_s[BCD_W-2:0], bin[i]};
      end
   end

   assign bcd = acc_s;

endmodule
`endif

// File: rtl/key_entry_adder.sv
// key_entry_adder: assembles two decimal operands from keypad events, adds them on EQUALS
// and holds the sum (plus optional BCD copy) for the display path.
// Optional feature macro: KEY_ENTRY_BCD_OUT_EN (enables the bin_to_bcd converter on sum_bcd).
//   clk, rst (async, active-low)
//   key_code/key_valid/key_ready : scanner key event handshake (ready low only in ADD)
//   entry_value/entry_sel        : operand being typed and which one (0 = A)
//   sum/sum_valid/sum_bcd        : result, valid in DONE
//   entry_err                    : one-cycle pulse when a digit is dropped on a full operand
module key_entry_adder
   import keypad_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int OP_W   = $clog2(10**DIGITS),
   parameter int SUM_W  = OP_W + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            key_code,
   input  logic                  key_valid,
   output logic                  key_ready,
   output logic [OP_W-1:0]       entry_value,
   output logic                  entry_sel,
   output logic [SUM_W-1:0]      sum,
   output logic                  sum_valid,
   output logic [4*(DIGITS+1)-1:0] sum_bcd,
   output logic                  entry_err
);

   localparam int                CNT_W    = $clog2(DIGITS + 1);
   localparam int                BCD_W    = 4 * (DIGITS + 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DIGITS);
   localparam logic [OP_W+3:0]   TEN      = (OP_W+4)'(10);

   state_t            state_r, state_s;
   logic [OP_W-1:0]   opa_r, opa_s;
   logic [OP_W-1:0]   opb_r, opb_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [SUM_W-1:0]  sum_r, sum_s, sum_add_s;
   logic              sum_valid_r, sum_valid_s;
   logic              err_r, err_s;

   logic              accept_s;
   logic              is_digit_s;
   logic [OP_W-1:0]   cur_s;
   logic [OP_W+3:0]   wide_s;
   logic [OP_W-1:0]   appended_s;

   assign accept_s   = key_valid && (state_r != ADD);
   assign is_digit_s = (key_code <= KEY_MAX_DIGIT);
   assign cur_s      = (state_r == ENTER_A) ? opa_r : opb_r;
   // A digit is only appended while cnt < DIGITS, so the result always fits OP_W.
   assign wide_s     = {4'd0, cur_s} * TEN + {{OP_W{1'b0}}, key_code};
   assign appended_s = wide_s[OP_W-1:0];
   assign sum_add_s  = SUM_W'(opa_r) + SUM_W'(opb_r);

   // Next-state, operand and result logic of the entry FSM.
   always_comb begin
      state_s     = state_r;
      opa_s       = opa_r;
      opb_s       = opb_r;
      cnt_s       = cnt_r;
      sum_s       = sum_r;
      sum_valid_s = sum_valid_r;
      err_s       = 1'b0;
      case (state_r)
         ENTER_A, ENTER_B: begin
            if (!accept_s) begin
               err_s = 1'b0;
            end else if (is_digit_s) begin
               if (cnt_r != CNT_FULL) begin
                  if (state_r == ENTER_A) begin
                     opa_s = appended_s;
                  end else begin
                     opb_s = appended_s;
                  end
                  cnt_s = cnt_r + 1'b1;
               end else begin
                  err_s = 1'b1;
               end
            end else begin
               case (key_code)
                  KEY_PLUS: begin
                     if (state_r == ENTER_A) begin
                        state_s = ENTER_B;
                        cnt_s   = {CNT_W{1'b0}};
                        opb_s   = {OP_W{1'b0}};
                     end else begin
                        state_s = state_r;
                     end
                  end
                  KEY_EQUALS: begin
                     if (state_r == ENTER_B) begin
                        state_s = ADD;
                     end else begin
                        state_s = state_r;
                     end
                  end
                  KEY_CLR_ENTRY: begin
                     if (state_r == ENTER_A) begin
                        opa_s = {OP_W{1'b0}};
                     end else begin
                        opb_s = {OP_W{1'b0}};
                     end
                     cnt_s = {CNT_W{1'b0}};
                  end
                  KEY_CLR_ALL: begin
                     state_s     = ENTER_A;
                     opa_s       = {OP_W{1'b0}};
                     opb_s       = {OP_W{1'b0}};
                     cnt_s       = {CNT_W{1'b0}};
                     sum_valid_s = 1'b0;
                  end
                  default: begin
                     state_s = state_r;
                  end
               endcase
            end
         end
         ADD: begin
            sum_s       = sum_add_s;
            sum_valid_s = 1'b1;
            state_s     = DONE;
         end
         DONE: begin
            if (!accept_s) begin
               state_s = state_r;
            end else if (is_digit_s) begin
               // A new digit starts a fresh calculation with that digit as A.
               opa_s       = {{(OP_W-4){1'b0}}, key_code};
               cnt_s       = CNT_W'(1);
               opb_s       = {OP_W{1'b0}};
               state_s     = ENTER_A;
               sum_valid_s = 1'b0;
            end else if (key_code == KEY_CLR_ALL) begin
               state_s     = ENTER_A;
               opa_s       = {OP_W{1'b0}};
               opb_s       = {OP_W{1'b0}};
               cnt_s       = {CNT_W{1'b0}};
               sum_valid_s = 1'b0;
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s = ENTER_A;
         end
      endcase
   end

   // State, operand and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ENTER_A;
         opa_r       <= {OP_W{1'b0}};
         opb_r       <= {OP_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         sum_r       <= {SUM_W{1'b0}};
         sum_valid_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         opa_r       <= opa_s;
         opb_r       <= opb_s;
         cnt_r       <= cnt_s;
         sum_r       <= sum_s;
         sum_valid_r <= sum_valid_s;
         err_r       <= err_s;
      end
   end

`ifdef KEY_ENTRY_BCD_OUT_EN
   logic [BCD_W-1:0] bcd_conv_s;
   logic [BCD_W-1:0] sum_bcd_r;

   bin_to_bcd #(
      .IN_W     (SUM_W),
      .DIGITS_N (DIGITS + 1)
   ) u_bin_to_bcd (
      .bin (sum_add_s),
      .bcd (bcd_conv_s)
   );

   // BCD copy is captured on the same ADD edge as the binary sum.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_bcd_r <= {BCD_W{1'b0}};
      end else if (state_r == ADD) begin
         sum_bcd_r <= bcd_conv_s;
      end else begin
         sum_bcd_r <= sum_bcd_r;
      end
   end

   assign sum_bcd = sum_bcd_r;
`else
   assign sum_bcd = {BCD_W{1'b0}};
`endif

   assign key_ready   = (state_r != ADD);
   assign entry_value = (state_r == ENTER_A) ? opa_r : opb_r;
   assign entry_sel   = (state_r != ENTER_A);
   assign sum         = sum_r;
   assign sum_valid   = sum_valid_r;
   assign entry_err   = err_r;

endmodule

// File: tb/tb_key_entry_adder.sv
// tb_key_entry_adder: directed test-plan sequences followed by random key traffic, all
// checked every cycle against a decimal-arithmetic model of the calculator.
module tb_key_entry_adder;

   localparam int DIGITS = 3;
   localparam int OP_W   = 10;
   localparam int SUM_W  = 11;
   localparam int BCD_W  = 16;

   logic              clk;
   logic              rst;
   logic [3:0]        key_code;
   logic              key_valid;
   logic              key_ready;
   logic [OP_W-1:0]   entry_value;
   logic              entry_sel;
   logic [SUM_W-1:0]  sum;
   logic              sum_valid;
   logic [BCD_W-1:0]  sum_bcd;
   logic              entry_err;

   int errors;
   int checks;

   // Model: mode 0 = typing A, 1 = typing B, 2 = adding, 3 = result shown.
   int m_mode, m_a, m_b, m_cnt, m_sum, m_err;

   key_entry_adder dut (
      .clk         (clk),
      .rst         (rst),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_ready   (key_ready),
      .entry_value (entry_value),
      .entry_sel   (entry_sel),
      .sum         (sum),
      .sum_valid   (sum_valid),
      .sum_bcd     (sum_bcd),
      .entry_err   (entry_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_bcd(input int s);
      logic [31:0] r;
      int v;
      r = 32'd0;
      v = s;
`ifdef KEY_ENTRY_BCD_OUT_EN
      for (int k = 0; k < DIGITS + 1; k++) begin
         r = r | (32'(v % 10) << (4 * k));
         v = v / 10;
      end
`endif
      return r;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_a = 0; m_b = 0; m_cnt = 0; m_sum = 0; m_err = 0;
   endtask

   task automatic model_clear_all();
      m_mode = 0; m_a = 0; m_b = 0; m_cnt = 0;
   endtask

   task automatic model_update(input bit v, input int c);
      m_err = 0;
      if (m_mode == 2) begin
         m_sum  = m_a + m_b;
         m_mode = 3;
      end else if (v && (m_mode == 0 || m_mode == 1)) begin
         if (c <= 9) begin
            if (m_cnt < DIGITS) begin
               if (m_mode == 0) m_a = m_a * 10 + c;
               else             m_b = m_b * 10 + c;
               m_cnt++;
            end else begin
               m_err = 1;
            end
         end else if (c == 10 && m_mode == 0) begin
            m_mode = 1; m_cnt = 0; m_b = 0;
         end else if (c == 13 && m_mode == 1) begin
            m_mode = 2;
         end else if (c == 11) begin
            if (m_mode == 0) m_a = 0;
            else             m_b = 0;
            m_cnt = 0;
         end else if (c == 12) begin
            model_clear_all();
         end
      end else if (v && m_mode == 3) begin
         if (c <= 9) begin
            m_a = c; m_cnt = 1; m_b = 0; m_mode = 0;
         end else if (c == 12) begin
            model_clear_all();
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".key_ready"},   32'(key_ready),   32'(m_mode != 2));
      chk({tag, ".entry_value"}, 32'(entry_value), 32'((m_mode == 0) ? m_a : m_b));
      chk({tag, ".entry_sel"},   32'(entry_sel),   32'(m_mode != 0));
      chk({tag, ".sum_valid"},   32'(sum_valid),   32'(m_mode == 3));
      chk({tag, ".sum"},         32'(sum),         32'(m_sum));
      chk({tag, ".sum_bcd"},     32'(sum_bcd),     exp_bcd(m_sum));
      chk({tag, ".entry_err"},   32'(entry_err),   32'(m_err));
   endtask

   // One clock: drive a key (or idle) away from the edge, then check after the edge.
   task automatic step(input string tag, input bit v, input logic [3:0] c);
      @(negedge clk);
      key_valid = v;
      key_code  = c;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      if (rst) model_update(v, int'(c));
      check_all(tag);
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      rst       = 1'b0;
      key_valid = 1'b0;
      key_code  = 4'h0;
      model_reset();
      #23;
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;

      // 1,2,PLUS,3,4,EQUALS -> 46
      step("t1_k1", 1'b1, 4'h1); chk("t1_ev1", 32'(entry_value), 32'd1);
      step("t1_k2", 1'b1, 4'h2); chk("t1_ev12", 32'(entry_value), 32'd12);
      step("t1_plus", 1'b1, 4'hA);
      step("t1_k3", 1'b1, 4'h3); chk("t1_ev3", 32'(entry_value), 32'd3);
      step("t1_k4", 1'b1, 4'h4); chk("t1_ev34", 32'(entry_value), 32'd34);
      step("t1_eq", 1'b1, 4'hD); chk("t1_sv_lat", 32'(sum_valid), 32'd0);
      step("t1_add", 1'b0, 4'h0);
      chk("t1_sum46", 32'(sum), 32'd46);
      chk("t1_sv", 32'(sum_valid), 32'd1);
`ifdef KEY_ENTRY_BCD_OUT_EN
      chk("t1_bcd", 32'(sum_bcd), 32'h0046);
`else
      chk("t1_bcd", 32'(sum_bcd), 32'h0000);
`endif

      // 9,9,9,9 overflow drop then +999 -> 1998
      step("t2_k9a", 1'b1, 4'h9);
      step("t2_k9b", 1'b1, 4'h9);
      step("t2_k9c", 1'b1, 4'h9);
      step("t2_k9d", 1'b1, 4'h9);
      chk("t2_err", 32'(entry_err), 32'd1);
      chk("t2_ev999", 32'(entry_value), 32'd999);
      step("t2_idle", 1'b0, 4'h0); chk("t2_err_once", 32'(entry_err), 32'd0);
      step("t2_plus", 1'b1, 4'hA);
      step("t2_b9a", 1'b1, 4'h9);
      step("t2_b9b", 1'b1, 4'h9);
      step("t2_b9c", 1'b1, 4'h9);
      step("t2_eq", 1'b1, 4'hD);
      step("t2_add", 1'b0, 4'h0);
      chk("t2_sum1998", 32'(sum), 32'd1998);

      // 5,CLR_ENTRY,7,PLUS,2,CLR_ALL,EQUALS
      step("t3_k5", 1'b1, 4'h5); chk("t3_ev5", 32'(entry_value), 32'd5);
      step("t3_ce", 1'b1, 4'hB); chk("t3_ev0", 32'(entry_value), 32'd0);
      step("t3_k7", 1'b1, 4'h7); chk("t3_ev7", 32'(entry_value), 32'd7);
      step("t3_plus", 1'b1, 4'hA);
      step("t3_k2", 1'b1, 4'h2); chk("t3_b2", 32'(entry_value), 32'd2);
      step("t3_ca", 1'b1, 4'hC);
      chk("t3_ca_ev", 32'(entry_value), 32'd0);
      chk("t3_ca_sel", 32'(entry_sel), 32'd0);
      step("t3_eq", 1'b1, 4'hD);
      step("t3_idle", 1'b0, 4'h0); chk("t3_eq_ign", 32'(key_ready), 32'd1);

      // 2+44=46, then 8 restarts, 8+0=8
      step("t4_k2", 1'b1, 4'h2);
      step("t4_plus", 1'b1, 4'hA);
      step("t4_k4a", 1'b1, 4'h4);
      step("t4_k4b", 1'b1, 4'h4);
      step("t4_eq", 1'b1, 4'hD);
      step("t4_add", 1'b0, 4'h0); chk("t4_sum46", 32'(sum), 32'd46);
      step("t4_k8", 1'b1, 4'h8);
      chk("t4_sv0", 32'(sum_valid), 32'd0);
      chk("t4_ev8", 32'(entry_value), 32'd8);
      chk("t4_sel0", 32'(entry_sel), 32'd0);
      step("t4_plus2", 1'b1, 4'hA);
      step("t4_k0", 1'b1, 4'h0);
      step("t4_eq2", 1'b1, 4'hD);
      step("t4_add2", 1'b0, 4'h0); chk("t4_sum8", 32'(sum), 32'd8);

      // key presented during ADD is lost
      step("t5_k1", 1'b1, 4'h1);
      step("t5_plus", 1'b1, 4'hA);
      step("t5_k1b", 1'b1, 4'h1);
      step("t5_eq", 1'b1, 4'hD); chk("t5_ready0", 32'(key_ready), 32'd0);
      step("t5_k5_add", 1'b1, 4'h5);
      chk("t5_sum2", 32'(sum), 32'd2);
      chk("t5_ev1", 32'(entry_value), 32'd1);

      // reset asserted in ENTER_B with A=12
      step("t6_k1", 1'b1, 4'h1);
      step("t6_k2", 1'b1, 4'h2);
      step("t6_plus", 1'b1, 4'hA);
      step("t6_k7", 1'b1, 4'h7);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all("t6_rst_async");
      step("t6_key_in_rst", 1'b1, 4'h6);
      @(negedge clk);
      rst = 1'b1;
      step("t6_k3", 1'b1, 4'h3);
      chk("t6_ev3", 32'(entry_value), 32'd3);
      chk("t6_sel0", 32'(entry_sel), 32'd0);

      // random key traffic
      for (int n = 0; n < 800; n++) begin
         step("rnd", ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
